// File: rtl/spi_slave_link_pkg.sv
// Purpose: shared types and constants for the SPI slave link (frame FSM states, frame limits, idle fill).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_link_pkg;

  // Frame state machine encoding
  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } link_state_t;

  // Highest byte index reported within one frame; later bytes saturate here
  localparam logic [3:0] SPI_FRAME_MAX_BYTE = 4'd15;

  // Byte shifted out on MISO whenever the TX FIFO has nothing to offer
  localparam logic [7:0] DEFAULT_IDLE_FILL = 8'hFF;

endpackage

// File: rtl/spi_slave_link_if.sv
// Purpose: bundles SPI pins, response-byte push port and RX/status outputs of the SPI slave link.
// Latency: n/a (wiring only).
// Backpressure: none on this bundle; tx_byte_valid is a strobe, overflow is reported via tx_overflow.
interface spi_slave_link_if #(
  parameter int CNT_W = 5
);
  logic             spi_sclk;
  logic             spi_cs_n;
  logic             spi_mosi;
  logic             spi_miso;
  logic [7:0]       tx_byte;
  logic             tx_byte_valid;
  logic [7:0]       spi_byte;
  logic             spi_input_valid;
  logic [3:0]       spi_byte_num;
  logic             frame_active;
  logic             frame_done;
  logic [CNT_W-1:0] tx_fifo_count;
  logic             tx_fifo_full;
  logic             tx_overflow;
  logic             frame_error;

  // Link side: samples pins and push strobe, drives MISO and status
  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, tx_byte, tx_byte_valid,
    output spi_miso, spi_byte, spi_input_valid, spi_byte_num,
           frame_active, frame_done, tx_fifo_count, tx_fifo_full,
           tx_overflow, frame_error
  );

  // Environment side: SPI master plus the response-byte producer
  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, tx_byte, tx_byte_valid,
    input  spi_miso, spi_byte, spi_input_valid, spi_byte_num,
           frame_active, frame_done, tx_fifo_count, tx_fifo_full,
           tx_overflow, frame_error
  );

endinterface

// File: rtl/spi_slave_link_tx_fifo.sv
// Purpose: synchronous response-byte FIFO with occupancy count, full flag and sticky overflow.
// Latency: push visible in count next cycle; pop_dat is combinational from the head entry.
// Backpressure: none upstream; a push while full (without a same-cycle pop) is dropped and sets overflow.
module spi_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf_q;
  logic             pop_ok;
  logic             push_ok;

  // A pop frees a slot in the same cycle, so push+pop while full both proceed
  assign pop_ok  = pop & (cnt != '0);
  assign push_ok = push & (!full | pop_ok);

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign count    = cnt;
  assign overflow = ovf_q;
  assign pop_dat  = mem[rd_ptr];

  // Storage array; contents need no reset because pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer, occupancy and sticky-overflow bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
      if (push && !push_ok) ovf_q <= 1'b1;
    end
  end

endmodule

// File: rtl/spi_slave_link.sv
// Purpose: SPI mode-0 slave (MSB first) deserializing MOSI bytes and serving MISO bytes from a TX FIFO.
// Latency: pin edges act SYNC_STAGES+1 sysClk later; spi_input_valid one cycle after the 8th SCLK rise is seen.
// Backpressure: none; RX bytes are strobed out unconditionally, TX pushes to a full FIFO drop and set tx_overflow.
// Optional: define SPI_PARTIAL_BYTE_ERR_EN to flag frames that end mid-byte on frame_error.
module spi_slave_link
  import spi_link_pkg::*;
#(
  parameter int         TX_FIFO_DEPTH = 16,
  parameter int         SYNC_STAGES   = 2,
  parameter logic [7:0] IDLE_FILL     = DEFAULT_IDLE_FILL
) (
  input logic          sysClk,
  input logic          reset,
  spi_slave_link_if.slave bus
);
  localparam int CNT_W = $clog2(TX_FIFO_DEPTH) + 1;

  logic [SYNC_STAGES-1:0] sclk_sr;
  logic [SYNC_STAGES-1:0] cs_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic                   sclk_prev;
  logic                   cs_prev;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_rise;
  logic                   cs_fall;

  link_state_t state;
  link_state_t state_nxt;
  logic        frame_start;
  logic        frame_end;
  logic        bit_in;
  logic        tx_shift_en;
  logic        byte_last;

  logic [2:0]  bit_cnt;
  logic [3:0]  byte_cnt;
  logic [7:0]  rx_shift;
  logic [7:0]  tx_shift;
  logic [7:0]  tx_load;
  logic [7:0]  spi_byte_q;
  logic        spi_valid_q;
  logic [3:0]  spi_num_q;
  logic        frame_done_q;

  logic             fifo_pop;
  logic [7:0]       fifo_pop_dat;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_overflow;

  // Pin synchronizers plus one history flop for SCLK/CS edge detection.
  // CS resets to "asserted" so a frame already running at reset is not mistaken for a new one.
  always_ff @(posedge sysClk) begin
    if (reset) begin
      sclk_sr   <= '0;
      cs_sr     <= '0;
      mosi_sr   <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], bus.spi_sclk};
      cs_sr     <= {cs_sr[SYNC_STAGES-2:0], bus.spi_cs_n};
      mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], bus.spi_mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign cs_s      = cs_sr[SYNC_STAGES-1];
  assign mosi_s    = mosi_sr[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = ~cs_s & cs_prev;

  // Frame state register
  always_ff @(posedge sysClk) begin
    if (reset) state <= WAIT_IDLE;
    else       state <= state_nxt;
  end

  // Next state and per-cycle frame controls; only CS edges move the FSM
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    bit_in      = 1'b0;
    tx_shift_en = 1'b0;
    case (state)
      WAIT_IDLE: begin
        if (cs_s) state_nxt = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          state_nxt   = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end else begin
          bit_in      = sclk_rise;
          tx_shift_en = sclk_fall & (bit_cnt != 3'd0);
        end
      end
      default: state_nxt = WAIT_IDLE;
    endcase
  end

  // The next TX byte is fetched at frame start and right after each completed byte
  assign byte_last = bit_in & (bit_cnt == 3'd7);
  assign fifo_pop  = frame_start | byte_last;
  assign tx_load   = fifo_empty ? IDLE_FILL : fifo_pop_dat;

  // RX deserializer, byte strobe, byte index and TX shifter
  always_ff @(posedge sysClk) begin
    if (reset) begin
      bit_cnt      <= 3'd0;
      byte_cnt     <= 4'd0;
      rx_shift     <= 8'd0;
      tx_shift     <= IDLE_FILL;
      spi_byte_q   <= 8'd0;
      spi_valid_q  <= 1'b0;
      spi_num_q    <= 4'd0;
      frame_done_q <= 1'b0;
    end else begin
      spi_valid_q  <= 1'b0;
      frame_done_q <= frame_end;
      if (frame_start) begin
        bit_cnt  <= 3'd0;
        byte_cnt <= 4'd0;
        tx_shift <= tx_load;
      end
      if (bit_in) begin
        rx_shift <= {rx_shift[6:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (byte_last) begin
          spi_byte_q  <= {rx_shift[6:0], mosi_s};
          spi_valid_q <= 1'b1;
          spi_num_q   <= byte_cnt;
          if (byte_cnt != SPI_FRAME_MAX_BYTE) byte_cnt <= byte_cnt + 4'd1;
          // Reloaded here; the falling edge that follows sees bit_cnt==0 and holds the new MSB
          tx_shift <= tx_load;
        end
      end
      if (tx_shift_en) begin
        tx_shift <= {tx_shift[6:0], 1'b1};
      end
    end
  end

`ifdef SPI_PARTIAL_BYTE_ERR_EN
  logic frame_error_q;

  // Flag a frame that closed with a partially received byte
  always_ff @(posedge sysClk) begin
    if (reset) frame_error_q <= 1'b0;
    else       frame_error_q <= frame_end & (bit_cnt != 3'd0);
  end

  assign bus.frame_error = frame_error_q;
`else
  assign bus.frame_error = 1'b0;
`endif

  spi_tx_fifo #(
    .DEPTH (TX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk      (sysClk),
    .reset    (reset),
    .push     (bus.tx_byte_valid),
    .push_dat (bus.tx_byte),
    .pop      (fifo_pop),
    .pop_dat  (fifo_pop_dat),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count),
    .overflow (fifo_overflow)
  );

  assign bus.spi_miso        = (state == ACTIVE) ? tx_shift[7] : 1'b1;
  assign bus.spi_byte        = spi_byte_q;
  assign bus.spi_input_valid = spi_valid_q;
  assign bus.spi_byte_num    = spi_num_q;
  assign bus.frame_active    = (state == ACTIVE) & ~cs_s;
  assign bus.frame_done      = frame_done_q;
  assign bus.tx_fifo_count   = fifo_count;
  assign bus.tx_fifo_full    = fifo_full;
  assign bus.tx_overflow     = fifo_overflow;

endmodule

// File: tb/tb_spi_slave_link.sv
// Purpose: randomized scoreboard bench for spi_slave_link against a frame-level reference model.
// Latency: checks RX bytes/indices, MISO bytes, frame_done/frame_error and FIFO status.
// Backpressure: n/a.
module tb_spi_slave_link;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  spi_slave_link_if #(.CNT_W(CNT_W)) bus ();

  spi_slave_link #(
    .TX_FIFO_DEPTH (DEPTH),
    .SYNC_STAGES   (2),
    .IDLE_FILL     (8'hFF)
  ) dut (
    .sysClk (clk),
    .reset  (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  tx_model[$];
  bit          ovf_exp;
  logic [7:0]  mosi_q[$];
  logic [11:0] exp_rx[$];
  bit          exp_done[$];
  logic [7:0]  miso_exp[$];
  logic [7:0]  miso_got[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_pop();
    if (tx_model.size() > 0) return tx_model.pop_front();
    return 8'hFF;
  endfunction

  function automatic void model_push(input logic [7:0] v);
    if (tx_model.size() < DEPTH) tx_model.push_back(v);
    else ovf_exp = 1'b1;
  endfunction

  // RX byte and frame-end monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.spi_input_valid) begin
        if (exp_rx.size() == 0) chk("rx_unexpected", {20'd0, bus.spi_byte_num, bus.spi_byte}, 32'hFFFF_FFFF);
        else chk("rx_byte_num", {20'd0, bus.spi_byte_num, bus.spi_byte}, {20'd0, exp_rx.pop_front()});
      end
      if (bus.frame_done) begin
        if (exp_done.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
        else chk("frame_error", {31'd0, bus.frame_error}, {31'd0, exp_done.pop_front()});
      end
    end
  end

  // MISO byte monitor
  always @(negedge clk) begin
    while (miso_got.size() > 0) begin
      if (miso_exp.size() == 0) chk("miso_unexpected", {24'd0, miso_got.pop_front()}, 32'hFFFF_FFFF);
      else chk("miso_byte", {24'd0, miso_got.pop_front()}, {24'd0, miso_exp.pop_front()});
    end
  end

  task automatic push_byte(input logic [7:0] v);
    @(negedge clk);
    bus.tx_byte       = v;
    bus.tx_byte_valid = 1'b1;
    @(negedge clk);
    bus.tx_byte_valid = 1'b0;
    model_push(v);
  endtask

  task automatic sclk_bit(input logic b);
    bus.spi_mosi = b;
    repeat (8) @(negedge clk);
    bus.spi_sclk = 1'b1;
    repeat (8) @(negedge clk);
    bus.spi_sclk = 1'b0;
  endtask

  // One SPI frame: nb whole bytes, then part extra bits; optionally push during frame start
  task automatic do_frame(input int nb, input int part, input bit full_push, input logic [7:0] pv);
    logic [7:0] cur, b, got;
    @(negedge clk);
    bus.spi_cs_n = 1'b0;
    if (full_push) begin
      bus.tx_byte       = pv;
      bus.tx_byte_valid = 1'b1;
    end
    repeat (6) @(negedge clk);
    bus.tx_byte_valid = 1'b0;
    cur = model_pop();
    if (full_push) model_push(pv);
    repeat (6) @(negedge clk);
    chk("frame_active_hi", {31'd0, bus.frame_active}, 32'd1);
    if (full_push) begin
      chk("full_pushpop_cnt", {27'd0, bus.tx_fifo_count}, tx_model.size());
      chk("full_pushpop_full", {31'd0, bus.tx_fifo_full}, 32'd1);
    end
    for (int i = 0; i < nb; i++) begin
      b = (mosi_q.size() > 0) ? mosi_q.pop_front() : 8'($urandom);
      exp_rx.push_back({4'((i > 15) ? 15 : i), b});
      miso_exp.push_back(cur);
      for (int k = 7; k >= 0; k--) begin
        bus.spi_mosi = b[k];
        repeat (8) @(negedge clk);
        got[k] = bus.spi_miso;
        bus.spi_sclk = 1'b1;
        repeat (8) @(negedge clk);
        bus.spi_sclk = 1'b0;
      end
      miso_got.push_back(got);
      cur = model_pop();
    end
    for (int k = 0; k < part; k++) sclk_bit(1'($urandom));
    repeat (8) @(negedge clk);
    bus.spi_cs_n = 1'b1;
`ifdef SPI_PARTIAL_BYTE_ERR_EN
    exp_done.push_back(part != 0);
`else
    exp_done.push_back(1'b0);
`endif
    repeat (12) @(negedge clk);
    chk("frame_active_lo", {31'd0, bus.frame_active}, 32'd0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b1;
    bus.spi_cs_n      = 1'b1;
    bus.spi_sclk      = 1'b0;
    bus.spi_mosi      = 1'b0;
    bus.tx_byte       = 8'd0;
    bus.tx_byte_valid = 1'b0;
    ovf_exp           = 1'b0;
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_miso", {31'd0, bus.spi_miso}, 32'd1);
    chk("rst_byte", {24'd0, bus.spi_byte}, 32'd0);
    chk("rst_num", {28'd0, bus.spi_byte_num}, 32'd0);
    chk("rst_count", {27'd0, bus.tx_fifo_count}, 32'd0);
    chk("rst_strobes", {28'd0, bus.spi_input_valid, bus.frame_done, bus.frame_error, bus.frame_active}, 32'd0);
    chk("rst_flags", {30'd0, bus.tx_overflow, bus.tx_fifo_full}, 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Plain two-byte frame
    mosi_q.push_back(8'hA5);
    mosi_q.push_back(8'h3C);
    do_frame(2, 0, 1'b0, 8'h00);

    // Response bytes, then one extra byte from the empty FIFO
    push_byte(8'h12);
    push_byte(8'h34);
    chk("cnt_two", {27'd0, bus.tx_fifo_count}, 32'd2);
    do_frame(3, 0, 1'b0, 8'h00);
    chk("cnt_drained", {27'd0, bus.tx_fifo_count}, 32'd0);

    // Long frame: byte index saturates
    do_frame(20, 0, 1'b0, 8'h00);

    // Overfill, then push and pop together while full
    for (int i = 0; i < 17; i++) push_byte(8'($urandom));
    chk("ovf_full", {31'd0, bus.tx_fifo_full}, 32'd1);
    chk("ovf_sticky", {31'd0, bus.tx_overflow}, {31'd0, ovf_exp});
    chk("ovf_count", {27'd0, bus.tx_fifo_count}, 32'd16);
    do_frame(16, 0, 1'b1, 8'h5A);
    chk("ovf_still", {31'd0, bus.tx_overflow}, 32'd1);
    chk("cnt_after_drain", {27'd0, bus.tx_fifo_count}, tx_model.size());

    // Frame ending after 5 bits, then a clean byte
    do_frame(0, 5, 1'b0, 8'h00);
    mosi_q.push_back(8'h81);
    do_frame(1, 0, 1'b0, 8'h00);

    // Randomized frames with interleaved pushes
    for (int f = 0; f < 5; f++) begin
      int np;
      np = $urandom_range(0, 5);
      for (int i = 0; i < np; i++) push_byte(8'($urandom));
      do_frame($urandom_range(1, 4), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0, 1'b0, 8'h00);
      chk("rand_count", {27'd0, bus.tx_fifo_count}, tx_model.size());
    end

    // Reset in the middle of a frame; link must wait for CS high before decoding again
    push_byte(8'hC3);
    push_byte(8'h99);
    @(negedge clk);
    bus.spi_cs_n = 1'b0;
    repeat (12) @(negedge clk);
    for (int k = 0; k < 3; k++) sclk_bit(1'($urandom));
    rst = 1'b1;
    tx_model.delete();
    ovf_exp = 1'b0;
    for (int k = 0; k < 2; k++) sclk_bit(1'($urandom));
    rst = 1'b0;
    for (int k = 0; k < 16; k++) sclk_bit(1'($urandom));
    chk("rst_mid_count", {27'd0, bus.tx_fifo_count}, 32'd0);
    chk("rst_mid_ovf", {31'd0, bus.tx_overflow}, {31'd0, ovf_exp});
    chk("rst_mid_active", {31'd0, bus.frame_active}, 32'd0);
    bus.spi_cs_n = 1'b1;
    repeat (12) @(negedge clk);
    do_frame(2, 0, 1'b0, 8'h00);

    repeat (20) @(negedge clk);
    chk("rx_leftover", exp_rx.size(), 32'd0);
    chk("done_leftover", exp_done.size(), 32'd0);
    chk("miso_leftover", miso_exp.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
